// File: rtl/clint_pkg.sv
// Shared types, register offsets and defaults for the core-local interruptor.
// Decode and byte-lane helpers are kept here so the top and the RTC agree on them.
package clint_pkg;

    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam int unsigned clint_rtc_div   = 1;

    localparam logic [15:0] clint_msip      = 16'h0000;
    localparam logic [15:0] clint_mtimecmp  = 16'h4000;
    localparam logic [15:0] clint_mtimecmph = 16'h4004;
    localparam logic [15:0] clint_mtime     = 16'hBFF8;
    localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

    typedef struct packed {
        logic        valid;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_in_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } clint_out_type;

    typedef enum logic {
        IDLE,
        RESP
    } clint_state_e;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } clint_reg_e;

    function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Window is 64 KiB aligned, so only the upper half of the base takes part.
    function automatic clint_reg_e clint_decode(input logic [31:0] addr,
                                                input logic [15:0] base_hi);
        clint_reg_e  sel;
        logic [15:0] off;
        off = addr[15:0] & 16'hFFFC;
        sel = REG_NONE;
        if (addr[31:16] == base_hi) begin
            case (off)
                clint_msip:      sel = REG_MSIP;
                clint_mtimecmp:  sel = REG_CMP_LO;
                clint_mtimecmph: sel = REG_CMP_HI;
                clint_mtime:     sel = REG_TIME_LO;
                clint_mtimeh:    sel = REG_TIME_HI;
                default:         sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/clint_rtc.sv
// Prescaler plus 64-bit mtime counter with per-half byte-masked write override.
// A write to one half freezes the other half for that cycle, so no carry crosses it.
module clint_rtc
    import clint_pkg::*;
#(
    parameter int unsigned rtc_div = clint_rtc_div
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned PW = (rtc_div > 1) ? $clog2(rtc_div) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          tick;

    assign tick = (presc_q == PW'(rtc_div - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (lo_we_i) begin
            mtime_d = {mtime_q[63:32], clint_merge(mtime_q[31:0], wdata_i, wstrb_i)};
        end else if (hi_we_i) begin
            mtime_d = {clint_merge(mtime_q[63:32], wdata_i, wstrb_i), mtime_q[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint.sv
// Memory-mapped msip/mtimecmp/mtime block for one hart; one-cycle request/response.
// Reads return register values from before the accept edge; ready pulses once per request.
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] clint_base = clint_base_addr,
    parameter int unsigned rtc_div    = clint_rtc_div
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_valid,
    input  logic        clint_wren,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    clint_in_type  req;
    clint_out_type resp_q;
    clint_state_e  state_q;
    clint_reg_e    sel;

    logic [63:0] mtime;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_q;
    logic [31:0] rdata_d;
    logic        accept;
    logic        do_wr;

    assign req = '{valid: clint_valid, wren: clint_wren, addr: clint_addr,
                   wdata: clint_wdata, wstrb: clint_wstrb};

    assign accept = (state_q == IDLE) && req.valid;
    assign do_wr  = accept && req.wren;
    assign sel    = clint_decode(req.addr, clint_base[31:16]);

    clint_rtc #(
        .rtc_div (rtc_div)
    ) u_rtc (
        .clk     (clk),
        .rst     (rst),
        .lo_we_i (do_wr && (sel == REG_TIME_LO)),
        .hi_we_i (do_wr && (sel == REG_TIME_HI)),
        .wdata_i (req.wdata),
        .wstrb_i (req.wstrb),
        .mtime_o (mtime)
    );

    always_comb begin
        rdata_d = 32'd0;
        if (!req.wren) begin
            case (sel)
                REG_MSIP:    rdata_d = {31'd0, msip_q};
                REG_CMP_LO:  rdata_d = mtimecmp_q[31:0];
                REG_CMP_HI:  rdata_d = mtimecmp_q[63:32];
                REG_TIME_LO: rdata_d = mtime[31:0];
                REG_TIME_HI: rdata_d = mtime[63:32];
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (do_wr) begin
            case (sel)
                REG_MSIP: begin
                    if (req.wstrb[0]) begin
                        msip_d = req.wdata[0];
                    end
                end
                REG_CMP_LO: mtimecmp_d[31:0]  = clint_merge(mtimecmp_q[31:0], req.wdata, req.wstrb);
                REG_CMP_HI: mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], req.wdata, req.wstrb);
                default: ;
            endcase
        end
    end

    // Request FSM with registered response; rdata is held at zero outside RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            resp_q     <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            timer_q    <= 1'b0;
        end else begin
            timer_q    <= (mtime >= mtimecmp_q);
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= RESP;
                        resp_q.ready <= 1'b1;
                        resp_q.rdata <= rdata_d;
                    end else begin
                        resp_q <= '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= '0;
                end
            endcase
        end
    end

    assign clint_rdata = resp_q.rdata;
    assign clint_ready = resp_q.ready;
    assign timer_irpt  = timer_q;
    assign soft_irpt   = msip_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: main instance with rtc_div=1, second with rtc_div=3 for the prescaler.
module tb_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic        clint_valid, valid3, clint_wren;
    logic [31:0] clint_addr, clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata, rdata3;
    logic        clint_ready, ready3;
    logic        timer_irpt, timer3;
    logic        soft_irpt, soft3;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_rdata, last_rdata3;
    logic        last_ready, last_timer, ready_after;

    localparam logic [31:0] A_MSIP   = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_TM_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_TM_HI  = 32'h0200_BFFC;

    always #5 clk = ~clk;

    clint dut (
        .clk         (clk),
        .rst         (rst),
        .clint_valid (clint_valid),
        .clint_wren  (clint_wren),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .timer_irpt  (timer_irpt),
        .soft_irpt   (soft_irpt)
    );

    clint #(.rtc_div(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .clint_valid (valid3),
        .clint_wren  (clint_wren),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (rdata3),
        .clint_ready (ready3),
        .timer_irpt  (timer3),
        .soft_irpt   (soft3)
    );

    // Bus driver: accept on the first posedge after driving, response sampled #1 later.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic both);
        @(negedge clk);
        clint_valid = 1'b1;
        valid3      = both;
        clint_wren  = wr;
        clint_addr  = addr;
        clint_wdata = wdata;
        clint_wstrb = strb;
        @(posedge clk);
        #1;
        last_ready  = clint_ready;
        last_rdata  = clint_rdata;
        last_rdata3 = rdata3;
        last_timer  = timer_irpt;
        clint_valid = 1'b0;
        valid3      = 1'b0;
        clint_wren  = 1'b0;
        clint_wstrb = 4'h0;
        @(posedge clk);
        #1;
        ready_after = clint_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clint_valid = 1'b0; valid3 = 1'b0; clint_wren = 1'b0;
        clint_addr = 32'h0; clint_wdata = 32'h0; clint_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({clint_ready, clint_rdata, timer_irpt, soft_irpt} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {clint_ready, clint_rdata, timer_irpt, soft_irpt});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        do_req(1'b0, A_TM_LO, 32'h0, 4'h0, 1'b1);
        checks++;
        if (last_rdata !== 32'd10) begin
            errors++; $display("FAIL mtime_after_10 got %0d want 10", last_rdata);
        end
        checks++;
        if (last_rdata3 !== 32'd3) begin
            errors++; $display("FAIL mtime_div3 got %0d want 3", last_rdata3);
        end
        checks++;
        if (timer_irpt !== 1'b0 || timer3 !== 1'b0) begin
            errors++; $display("FAIL timer_after_reset got %b%b want 00", timer_irpt, timer3);
        end
        checks++;
        if (last_ready !== 1'b1 || ready_after !== 1'b0) begin
            errors++; $display("FAIL ready_pulse got %b%b want 10", last_ready, ready_after);
        end
    endtask

    task automatic test_timer();
        do_req(1'b1, A_CMP_HI, 32'h0, 4'hF, 1'b0);
        do_req(1'b1, A_TM_LO, 32'h0, 4'hF, 1'b0);
        do_req(1'b1, A_CMP_LO, 32'd20, 4'hF, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (timer_irpt !== 1'b0) begin
            errors++; $display("FAIL timer_at_19 got %b want 0", timer_irpt);
        end
        @(posedge clk); #1;
        checks++;
        if (timer_irpt !== 1'b0) begin
            errors++; $display("FAIL timer_reach_20 got %b want 0", timer_irpt);
        end
        @(posedge clk); #1;
        checks++;
        if (timer_irpt !== 1'b1) begin
            errors++; $display("FAIL timer_rise got %b want 1", timer_irpt);
        end
        do_req(1'b1, A_CMP_LO, 32'hFFFF_FFFF, 4'hF, 1'b0);
        checks++;
        if (last_timer !== 1'b1) begin
            errors++; $display("FAIL timer_lag got %b want 1", last_timer);
        end
        checks++;
        if (timer_irpt !== 1'b0) begin
            errors++; $display("FAIL timer_fall got %b want 0", timer_irpt);
        end
    endtask

    task automatic test_soft();
        do_req(1'b1, A_MSIP, 32'h1, 4'hF, 1'b0);
        checks++;
        if (soft_irpt !== 1'b1) begin
            errors++; $display("FAIL soft_set got %b want 1", soft_irpt);
        end
        do_req(1'b0, A_MSIP, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h1) begin
            errors++; $display("FAIL msip_read1 got %h want 1", last_rdata);
        end
        do_req(1'b1, A_MSIP, 32'h0, 4'hF, 1'b0);
        checks++;
        if (soft_irpt !== 1'b0) begin
            errors++; $display("FAIL soft_clr got %b want 0", soft_irpt);
        end
        do_req(1'b0, A_MSIP, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++; $display("FAIL msip_read0 got %h want 0", last_rdata);
        end
        do_req(1'b1, A_MSIP, 32'hFFFF_FFFE, 4'hF, 1'b0);
        do_req(1'b0, A_MSIP, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0 || soft_irpt !== 1'b0) begin
            errors++; $display("FAIL msip_fffe got %h/%b want 0/0", last_rdata, soft_irpt);
        end
        do_req(1'b1, A_MSIP, 32'h1, 4'b1110, 1'b0);
        checks++;
        if (soft_irpt !== 1'b0) begin
            errors++; $display("FAIL msip_lane0_off got %b want 0", soft_irpt);
        end
        do_req(1'b1, A_MSIP | 32'h2, 32'h1, 4'b0001, 1'b0);
        checks++;
        if (soft_irpt !== 1'b1) begin
            errors++; $display("FAIL msip_low_addr_bits got %b want 1", soft_irpt);
        end
        do_req(1'b1, A_MSIP, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_carry();
        do_req(1'b1, A_TM_HI, 32'h0, 4'hF, 1'b0);
        do_req(1'b1, A_TM_LO, 32'hFFFF_FFFF, 4'hF, 1'b0);
        do_req(1'b0, A_TM_LO, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++; $display("FAIL mtime_lo_wrap got %h want 0", last_rdata);
        end
        do_req(1'b0, A_TM_HI, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h1) begin
            errors++; $display("FAIL mtime_hi_carry got %h want 1", last_rdata);
        end
        do_req(1'b0, A_TM_LO, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h4) begin
            errors++; $display("FAIL mtime_lo_after got %h want 4", last_rdata);
        end
    endtask

    task automatic test_wstrb();
        do_req(1'b1, A_CMP_LO, 32'hAABB_CCDD, 4'b0010, 1'b0);
        do_req(1'b0, A_CMP_LO, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'hFFFF_CCFF) begin
            errors++; $display("FAIL cmp_lo_wstrb got %h want ffffccff", last_rdata);
        end
        do_req(1'b0, A_CMP_HI, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++; $display("FAIL cmp_hi_keep got %h want 0", last_rdata);
        end
    endtask

    task automatic test_unmapped();
        do_req(1'b0, 32'h0200_1234, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0 || last_ready !== 1'b1 || ready_after !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read got %h/%b%b want 0/10", last_rdata, last_ready, ready_after);
        end
        do_req(1'b0, 32'h0300_BFF8, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'h0 || last_ready !== 1'b1) begin
            errors++; $display("FAIL outside_read got %h/%b want 0/1", last_rdata, last_ready);
        end
        do_req(1'b1, 32'h0300_0000, 32'h1, 4'hF, 1'b0);
        checks++;
        if (soft_irpt !== 1'b0 || last_ready !== 1'b1) begin
            errors++; $display("FAIL outside_write got %b/%b want 0/1", soft_irpt, last_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_req(1'b1, A_MSIP, 32'h1, 4'hF, 1'b0);
        checks++;
        if (soft_irpt !== 1'b1 || timer_irpt !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq got %b%b want 11", soft_irpt, timer_irpt);
        end
        @(negedge clk);
        clint_valid = 1'b1; clint_wren = 1'b0; clint_addr = A_TM_LO;
        @(posedge clk); #1;
        checks++;
        if (clint_ready !== 1'b1) begin
            errors++; $display("FAIL resp_before_rst got %b want 1", clint_ready);
        end
        rst = 1'b1;
        clint_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({clint_ready, clint_rdata, timer_irpt, soft_irpt} !== 35'd0) begin
            errors++;
            $display("FAIL rst_in_resp got %h want 0", {clint_ready, clint_rdata, timer_irpt, soft_irpt});
        end
        @(negedge clk);
        clint_valid = 1'b1; clint_wren = 1'b1; clint_addr = A_MSIP;
        clint_wdata = 32'h1; clint_wstrb = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (clint_ready !== 1'b0 || soft_irpt !== 1'b0) begin
            errors++; $display("FAIL rst_drops_req got %b%b want 00", clint_ready, soft_irpt);
        end
        @(negedge clk);
        rst = 1'b0;
        clint_valid = 1'b0; clint_wren = 1'b0; clint_wstrb = 4'h0;
        do_req(1'b0, A_TM_LO, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'd1) begin
            errors++; $display("FAIL mtime_post_rst got %0d want 1", last_rdata);
        end
        do_req(1'b0, A_CMP_HI, 32'h0, 4'h0, 1'b0);
        checks++;
        if (last_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cmp_post_rst got %h want ffffffff", last_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timer();
        test_soft();
        test_carry();
        test_wstrb();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
